data_memory_sized: RTL

- Parametrised byte-addressed data memory for the single-cycle/pipelined MIPS datapath; successor to the word-only data memory.
- Supports byte/half/word stores with lane masking; loads are sign- or zero-extended.
- Registered read with a valid flag; flags misaligned and out-of-range accesses.
- Sits in the MEM stage between ALU result (address) and the write-back mux.

---
 rtl/data_memory_sized.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_memory_sized.sv
// Byte-addressed MIPS data memory: byte/half/word stores with lane masks, sign/zero-extended registered loads.
// Define DMEM_STATS_EN to add load/store/error counters.
module data_memory_sized #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  memWrite,
    input  logic                  memRead,
    input  logic [1:0]            memSize,
    input  logic                  memSigned,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    output logic [31:0]           readData,
    output logic                  readValid,
    output logic                  accessError
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]           readCount,
    output logic [31:0]           writeCount,
    output logic [15:0]           errorCount
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH * 4);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   readData_q, readData_d;
    logic          readValid_q, readValid_d;
    logic          accessError_q, accessError_d;

    logic [IW-1:0] word_idx;
    logic [1:0]    lane;
    logic          req, err, wr_ok, rd_ok;
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;

    assign word_idx = address[IW+1:2];
    assign lane     = address[1:0];
    assign req      = memRead | memWrite;

    always_comb begin
        err = 1'b0;
        if (req) begin
            if (memSize == 2'b11)                        err = 1'b1;
            if (memSize == 2'b01 && lane[0])             err = 1'b1;
            if (memSize == 2'b10 && lane != 2'b00)       err = 1'b1;
            if ({1'b0, address} >= LIMIT)                err = 1'b1;
        end
    end

    assign wr_ok = memWrite & ~err;
    assign rd_ok = memRead & ~err;

    // Store data is replicated across lanes so the byte-enable alone picks the destination.
    always_comb begin
        be   = 4'b1111;
        wdat = writeData;
        case (memSize)
            2'b00: begin
                be   = 4'b0001 << lane;
                wdat = {4{writeData[7:0]}};
            end
            2'b01: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wdat = {2{writeData[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wdat = writeData;
            end
        endcase
    end

    always_comb begin
        rd_word  = mem_q[word_idx];
        rd_byte  = rd_word[{lane, 3'b000} +: 8];
        rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (memSize)
            2'b00:   load_val = memSigned ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
            2'b01:   load_val = memSigned ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        readData_d    = rd_ok ? load_val : readData_q;
        readValid_d   = rd_ok;
        accessError_d = err;
    end

    // Read uses the pre-edge word, giving read-before-write on a combined request.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[word_idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            readData_q    <= '0;
            readValid_q   <= 1'b0;
            accessError_q <= 1'b0;
        end else begin
            readData_q    <= readData_d;
            readValid_q   <= readValid_d;
            accessError_q <= accessError_d;
        end
    end

    assign readData    = readData_q;
    assign readValid   = readValid_q;
    assign accessError = accessError_q;

`ifdef DMEM_STATS_EN
    logic [31:0] readCount_q, writeCount_q;
    logic [15:0] errorCount_q;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            readCount_q  <= '0;
            writeCount_q <= '0;
            errorCount_q <= '0;
        end else begin
            if (rd_ok) readCount_q <= readCount_q + 32'd1;
            if (wr_ok) writeCount_q <= writeCount_q + 32'd1;
            if (err && errorCount_q != 16'hFFFF) errorCount_q <= errorCount_q + 16'd1;
        end
    end

    assign readCount  = readCount_q;
    assign writeCount = writeCount_q;
    assign errorCount = errorCount_q;
`endif

endmodule
